// File: rtl/chmu_pkg.sv
// Shared types and defaults for the CHMU hot-page path (tracker and hot queue).
package chmu_pkg;

  localparam int ADDR_SIZE      = 21;
  localparam int CNT_SIZE       = 12;
  localparam int EPOCH_W        = 8;
  localparam int DEFAULT_DEPTH  = 64;
  localparam int DEFAULT_IRQ_TH = 16;
  localparam int DEFAULT_DROP_W = 16;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [CNT_SIZE-1:0]  cnt;
    logic [EPOCH_W-1:0]   epoch;
  } hot_entry_t;

endpackage

// File: rtl/chmu_sync_fifo.sv
// Generic first-word-fall-through FIFO: inferred RAM with registered read plus a
// write-to-head bypass so a push into an empty queue is visible one edge later.
module chmu_sync_fifo
  import chmu_pkg::*;
#(
  parameter int WIDTH = ADDR_SIZE + CNT_SIZE + EPOCH_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] level_next
);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_addr;
  logic [LVL_W-1:0] level_reg;
  logic             push_ok;
  logic             pop_ok;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_q_reg;
  logic [WIDTH-1:0] byp_data_reg;
  logic             byp_sel_reg;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == LVL_W'(DEPTH));
  assign pop_ok  = pop && !empty && !clear;
  assign push_ok = push && (!full || pop_ok) && !clear;

  // Read address looks one entry ahead on a pop so the new head is ready next cycle.
  assign rd_addr = pop_ok ? (rd_ptr_reg + PTR_W'(1)) : rd_ptr_reg;

  always_comb begin
    level_next = level_reg;
    if (clear) begin
      level_next = '0;
    end else if (push_ok && !pop_ok) begin
      level_next = level_reg + LVL_W'(1);
    end else if (pop_ok && !push_ok) begin
      level_next = level_reg - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
    ram_q_reg <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      byp_sel_reg  <= 1'b0;
      byp_data_reg <= '0;
    end else if (clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      byp_sel_reg  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      rd_ptr_reg   <= rd_addr;
      level_reg    <= level_next;
      // RAM returns old data when the written slot is the one being read.
      byp_sel_reg  <= push_ok && (wr_ptr_reg == rd_addr);
      byp_data_reg <= wr_data;
    end
  end

  assign level   = level_reg;
  assign rd_data = empty ? '0 : (byp_sel_reg ? byp_data_reg : ram_q_reg);

endmodule

// File: rtl/chmu_hot_queue.sv
// Hot-page event queue: epoch tagging, drop accounting and level irq around a FWFT FIFO.
// Optional CHMU_HOTQ_DEDUP_EN discards back-to-back repeats of the same page within an epoch.
module chmu_hot_queue
  import chmu_pkg::*;
#(
  parameter int ADDR_SIZE = chmu_pkg::ADDR_SIZE,
  parameter int CNT_SIZE  = chmu_pkg::CNT_SIZE,
  parameter int DEPTH     = chmu_pkg::DEFAULT_DEPTH,
  parameter int EPOCH_W   = chmu_pkg::EPOCH_W,
  parameter int DROP_W    = chmu_pkg::DEFAULT_DROP_W,
  parameter int IRQ_TH    = chmu_pkg::DEFAULT_IRQ_TH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [ADDR_SIZE-1:0]     in_addr,
  input  logic [CNT_SIZE-1:0]      in_cnt,
  input  logic                     epoch,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_SIZE-1:0]     out_addr,
  output logic [CNT_SIZE-1:0]      out_cnt,
  output logic [EPOCH_W-1:0]       out_epoch,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     irq
);

  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_SIZE + CNT_SIZE + EPOCH_W;

  logic [EPOCH_W-1:0] epoch_id_reg;
  logic [DROP_W-1:0]  drop_cnt_reg;
  logic               irq_reg;
  logic               push_req;
  logic               drop;
  logic               dup_hit;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   level_next;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;

`ifdef CHMU_HOTQ_DEDUP_EN
  logic [ADDR_SIZE-1:0] last_addr_reg;
  logic                 last_valid_reg;
  logic                 push_acc;

  assign dup_hit  = last_valid_reg && (in_addr == last_addr_reg);
  // Full implies non-empty, so out_ready alone frees a slot.
  assign push_acc = push_req && (!fifo_full || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_reg  <= '0;
      last_valid_reg <= 1'b0;
    end else if (clear || epoch) begin
      last_valid_reg <= 1'b0;
    end else if (push_acc) begin
      last_addr_reg  <= in_addr;
      last_valid_reg <= 1'b1;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  assign push_req = in_valid && !dup_hit;
  assign drop     = push_req && fifo_full && !out_ready && !clear;
  assign wr_data  = {in_addr, in_cnt, epoch_id_reg};

  chmu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_req),
    .pop        (out_ready),
    .clear      (clear),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (level),
    .level_next (level_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch_id_reg <= '0;
    end else if (epoch) begin
      epoch_id_reg <= epoch_id_reg + EPOCH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg <= '0;
    end else if (clear) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != '1)) begin
      drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
    end
  end

  // irq tracks the level the queue will hold after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= (level_next >= LVL_W'(IRQ_TH));
    end
  end

  assign out_valid = !fifo_empty;
  assign out_addr  = rd_data[ENTRY_W-1 -: ADDR_SIZE];
  assign out_cnt   = rd_data[EPOCH_W +: CNT_SIZE];
  assign out_epoch = rd_data[EPOCH_W-1:0];
  assign drop_cnt  = drop_cnt_reg;
  assign irq       = irq_reg;

endmodule

// File: doc/chmu_hot_queue.md
Name: chmu_hot_queue

Overview:
Consumer end of the hot-page detection stream. It accepts the one-cycle hot-page pulses (addr, cnt) produced by the counter-set tracker. Each event is tagged with the current epoch number and buffered in a FIFO. A valid/ready pop port serves the host/CSR drain logic, with level, drop accounting and a threshold interrupt.

Parameters:
ADDR_SIZE, 21, hot-page address width (4KB DPA units)
CNT_SIZE, 12, access-count width carried with each event
DEPTH, 64, FIFO entries (power of two, >=4)
EPOCH_W, 8, epoch tag width
DROP_W, 16, drop counter width
IRQ_TH, 16, level at/above which irq asserts (1..DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  one-cycle hot event pulse, no backpressure
in_addr  in  ADDR_SIZE  hot page address
in_cnt  in  CNT_SIZE  count at detection
epoch  in  1  epoch boundary pulse (same signal fed to the tracker)
clear  in  1  synchronous flush request from CSR
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head
out_addr  out  ADDR_SIZE  head address
out_cnt  out  CNT_SIZE  head count
out_epoch  out  EPOCH_W  head epoch tag
level  out  $clog2(DEPTH)+1  current occupancy
drop_cnt  out  DROP_W  events lost to full queue
irq  out  1  level >= IRQ_TH

Behaviour:
- Reset: asynchronous on rst_n low. All outputs 0, pointers 0, epoch_id 0, storage contents don't-care.
- Push: when in_valid and (not full, or pop in the same cycle). Stores {in_addr, in_cnt, epoch_id}. in_valid has no ready; rejected events are lost.
- Drop: in_valid while full with no simultaneous pop. drop_cnt increments, saturating at all-ones with no wrap.
- Pop: out_valid && out_ready advances the head. out_* are first-word-fall-through and stable while out_valid && !out_ready.
- Latency: an event pushed at edge N gives out_valid=1 after edge N when the queue was empty.
- Simultaneous push+pop when full: both occur and level is unchanged.
- When empty: out_valid=0, so no pop occurs; a push still occurs.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Full/empty are resolved by the level counter.
- epoch: epoch_id <= epoch_id+1 and wraps at 2^EPOCH_W. An in_valid coincident with epoch is pushed with the pre-increment tag. Queue contents are not flushed.
- clear: highest priority. Level, pointers and drop_cnt go to 0 and out_valid=0 next cycle. Any push or pop in the same cycle is ignored. epoch_id is unchanged.
- irq: registered, updated from next-state level. Level-sensitive; deasserts once level < IRQ_TH.
- level: registered, exact occupancy 0..DEPTH.

Optional Feature:
CHMU_HOTQ_DEDUP_EN
- Defined: hold the last-pushed address plus a valid flag. An in_valid whose in_addr equals the last pushed address, in the same epoch_id, is discarded silently: no push, no drop count.
  - The valid flag clears on epoch, clear and reset.
  - A discarded duplicate does not update the stored address.
- Undefined: every in_valid is pushed or dropped as above. No compare logic is instantiated.

Decomposition:
- Package chmu_pkg holds:
  - typedef hot_entry_t packed {addr, cnt, epoch}, parameterized via localparams ADDR_SIZE=21, CNT_SIZE=12, EPOCH_W=8, shared with the tracker.
  - constants for default DEPTH and IRQ_TH.
- One sub-module, chmu_sync_fifo: generic FWFT storage (register array or inferred RAM with bypass) with push/pop/clear, full/empty, level.
- Top-level holds epoch tag, drop counter, irq, dedup.

Test Plan:
- Reset then 3 pulses (addr 0x10, 0x20, 0x30; cnt 20) with out_ready=0 -> level=3, out_addr=0x10, out_epoch=0. Then out_ready=1 for 3 cycles -> pops 0x10, 0x20, 0x30 in order; level=0, out_valid=0.
- 64 pulses with out_ready=0, then 2 more -> level=64, drop_cnt=2. 65th pulse with out_ready=1 the same cycle -> accepted, level=64, drop_cnt unchanged.
- Push 0x5, pulse epoch, push 0x6; also in_valid coincident with epoch (0x7) -> tags: 0x5 gets 0, 0x7 gets 0, 0x6 gets 1. After 256 epoch pulses the tag wraps to 0.
- Fill to 15 -> irq=0. 16th push -> irq=1 next cycle. Pop one -> irq=0.
- With level=10 and drop_cnt=3, assert clear alongside in_valid and out_ready -> next cycle level=0, drop_cnt=0, out_valid=0, irq=0. Assert rst_n low mid-stream -> all outputs 0 immediately.
- CHMU_HOTQ_DEDUP_EN: push 0x40, 0x40, 0x41, 0x40 -> queue holds 0x40, 0x41, 0x40. Then epoch, then 0x40 -> accepted with tag+1.
